// File: rtl/exception_ctrl.sv
// Exception sequencing controller: captures ELR/ESR, drains the pipeline for a
// fixed number of cycles, redirects fetch to the vector, and returns on ERET.
module exception_ctrl #(
  parameter int unsigned N            = 64,
  parameter logic [N-1:0] VECTOR_ADDR = N'(64'hD8),
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_id,
  input  logic         not_an_instr,
  input  logic         eret,
  input  logic         irq,
  output logic         irq_ack,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         exc_flush,
  output logic         stall,
  output logic         pc_redirect,
  output logic [N-1:0] pc_target,
  output logic         in_handler
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES);

  localparam logic [3:0] ESR_INVALID = 4'b0001;
  localparam logic [3:0] ESR_IRQ     = 4'b0010;
  localparam logic [3:0] ESR_ERET    = 4'b0011;
  localparam logic [3:0] ESR_DOUBLE  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    HANDLER  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     elr_q, elr_d;
  logic [3:0]       esr_q, esr_d;

  // State, drain counter and syndrome registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      elr_q   <= '0;
      esr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
    end
  end

  // Next-state and pipeline control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    elr_d       = elr_q;
    esr_d       = esr_q;
    irq_ack     = 1'b0;
    exc_flush   = 1'b0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    in_handler  = 1'b0;

    case (state_q)
      IDLE: begin
        if (not_an_instr) begin
          elr_d   = pc_id;
          esr_d   = ESR_INVALID;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end else if (eret) begin
          elr_d   = pc_id;
          esr_d   = ESR_ERET;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end else if (irq) begin
          // Decode instruction is re-executed after return, so its PC is saved
          elr_d   = pc_id;
          esr_d   = ESR_IRQ;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
          irq_ack = ~reset;
        end
      end

      FLUSH: begin
        exc_flush = 1'b1;
        stall     = 1'b1;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = REDIRECT;
        end
      end

      REDIRECT: begin
        pc_redirect = 1'b1;
        pc_target   = VECTOR_ADDR;
        exc_flush   = 1'b1;
        state_d     = HANDLER;
      end

      HANDLER: begin
        in_handler = 1'b1;
        if (not_an_instr) begin
          // Fault inside the handler: keep the original return PC
          esr_d   = ESR_DOUBLE;
          cnt_d   = CNT_INIT;
          state_d = FLUSH;
        end else if (eret) begin
          pc_redirect = 1'b1;
          pc_target   = elr_q;
          exc_flush   = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign elr = elr_q;
  assign esr = esr_q;

endmodule
